// File: rtl/timer_pkg.sv
// Shared types and digit-index constants for the mm:ss BCD timer.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [1:0] DIG_SEC_O = 2'd0;
  localparam logic [1:0] DIG_SEC_T = 2'd1;
  localparam logic [1:0] DIG_MIN_O = 2'd2;
  localparam logic [1:0] DIG_MIN_T = 2'd3;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
  } tm_t;

endpackage

// File: rtl/timer_tick.sv
// One-second tick divider: counts 0..TICK_DIV-1 while running, pulses tick on the last count.
module timer_tick #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] div_cnt_q, div_cnt_d;

  assign tick = run && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (run) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/timer_core.sv
// BCD mm:ss up/down timer with digit load and optional lap capture.
// Lap capture is built only when TIMER_CORE_LAP_EN is defined.
module timer_core import timer_pkg::*; #(
  parameter int TICK_DIV = 100_000_000,
  parameter int MAX_MIN  = 59,
  parameter int WRAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       load,
  input  logic [1:0] load_sel,
  input  logic [3:0] load_val,
  input  logic       lap,
  output bcd_t       min_t,
  output bcd_t       min_o,
  output bcd_t       sec_t,
  output bcd_t       sec_o,
  output bcd_t       lap_min_t,
  output bcd_t       lap_min_o,
  output bcd_t       lap_sec_t,
  output bcd_t       lap_sec_o,
  output logic       lap_vld,
  output logic       expired,
  output logic       wrapped
);

  localparam bcd_t       MAX_MT    = bcd_t'(MAX_MIN / 10);
  localparam bcd_t       MAX_MO    = bcd_t'(MAX_MIN % 10);
  localparam logic [7:0] MAX_MIN_V = 8'(MAX_MIN);

  function automatic bcd_t clamp_digit(input bcd_t v, input bcd_t lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [7:0] minute_val(input bcd_t t, input bcd_t o);
    return ({4'd0, t} * 8'd10) + {4'd0, o};
  endfunction

  tm_t  time_q, time_d;
  logic expired_q, expired_d;
  logic wrapped_q, wrapped_d;
  logic tick;
  logic at_max;

  timer_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (load),
    .tick (tick)
  );

  assign at_max = (time_q.min_t == MAX_MT) && (time_q.min_o == MAX_MO);

  always_comb begin
    time_d    = time_q;
    expired_d = 1'b0;
    wrapped_d = 1'b0;
    if (load) begin
      case (load_sel)
        DIG_SEC_O: time_d.sec_o = clamp_digit(load_val, DIGIT_MAX);
        DIG_SEC_T: time_d.sec_t = clamp_digit(load_val, SEC_T_MAX);
        DIG_MIN_O: time_d.min_o = clamp_digit(load_val, DIGIT_MAX);
        default:   time_d.min_t = load_val;
      endcase
      // An out-of-range minute pins both minute digits to the maximum.
      if (minute_val(time_d.min_t, time_d.min_o) > MAX_MIN_V) begin
        time_d.min_t = MAX_MT;
        time_d.min_o = MAX_MO;
      end
    end else if (tick) begin
      if (!dir) begin
        if (time_q.sec_o != DIGIT_MAX) begin
          time_d.sec_o = time_q.sec_o + 4'd1;
        end else begin
          time_d.sec_o = 4'd0;
          if (time_q.sec_t != SEC_T_MAX) begin
            time_d.sec_t = time_q.sec_t + 4'd1;
          end else begin
            time_d.sec_t = 4'd0;
            if (at_max) begin
              if (WRAP != 0) begin
                time_d    = '0;
                wrapped_d = 1'b1;
              end else begin
                time_d = time_q;
              end
            end else if (time_q.min_o == DIGIT_MAX) begin
              time_d.min_o = 4'd0;
              time_d.min_t = time_q.min_t + 4'd1;
            end else begin
              time_d.min_o = time_q.min_o + 4'd1;
            end
          end
        end
      end else if (time_q != '0) begin
        if (time_q.sec_o != 4'd0) begin
          time_d.sec_o = time_q.sec_o - 4'd1;
        end else begin
          time_d.sec_o = DIGIT_MAX;
          if (time_q.sec_t != 4'd0) begin
            time_d.sec_t = time_q.sec_t - 4'd1;
          end else begin
            time_d.sec_t = SEC_T_MAX;
            if (time_q.min_o != 4'd0) begin
              time_d.min_o = time_q.min_o - 4'd1;
            end else begin
              time_d.min_o = DIGIT_MAX;
              time_d.min_t = time_q.min_t - 4'd1;
            end
          end
        end
        // Only 00:01 can step down to 00:00.
        expired_d = (time_q.min_t == 4'd0) && (time_q.min_o == 4'd0) &&
                    (time_q.sec_t == 4'd0) && (time_q.sec_o == 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q    <= '0;
      expired_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      time_q    <= time_d;
      expired_q <= expired_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign min_t   = time_q.min_t;
  assign min_o   = time_q.min_o;
  assign sec_t   = time_q.sec_t;
  assign sec_o   = time_q.sec_o;
  assign expired = expired_q;
  assign wrapped = wrapped_q;

`ifdef TIMER_CORE_LAP_EN
  tm_t  lap_q, lap_d;
  logic lap_vld_q, lap_vld_d;

  // Capture the post-update value so a lap on a tick edge shows the new time.
  always_comb begin
    lap_d     = lap_q;
    lap_vld_d = lap_vld_q;
    if (lap) begin
      lap_d     = time_d;
      lap_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q     <= '0;
      lap_vld_q <= 1'b0;
    end else begin
      lap_q     <= lap_d;
      lap_vld_q <= lap_vld_d;
    end
  end

  assign lap_min_t = lap_q.min_t;
  assign lap_min_o = lap_q.min_o;
  assign lap_sec_t = lap_q.sec_t;
  assign lap_sec_o = lap_q.sec_o;
  assign lap_vld   = lap_vld_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_min_t  = '0;
  assign lap_min_o  = '0;
  assign lap_sec_t  = '0;
  assign lap_sec_o  = '0;
  assign lap_vld    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: a wrapping and a saturating instance share stimulus;
// the reference model tracks time as a plain seconds count.
module tb_timer_core;

  localparam int TD   = 4;
  localparam int MM   = 59;
  localparam int MAXS = MM * 60 + 59;

  logic       clk = 1'b0;
  logic       rst, run, dir, load, lap;
  logic [1:0] load_sel;
  logic [3:0] load_val;

  logic [3:0] d_mt[2], d_mo[2], d_st[2], d_so[2];
  logic [3:0] d_lmt[2], d_lmo[2], d_lst[2], d_lso[2];
  logic       d_vld[2], d_exp[2], d_wrp[2];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_secs[2], m_lap[2], m_div, m_vld;
  bit m_wrp[2], m_exp[2];
  int m_wrp_cnt[2], m_exp_cnt[2], d_wrp_cnt[2], d_exp_cnt[2];

  always #5 clk = ~clk;

  timer_core #(.TICK_DIV(TD), .MAX_MIN(MM), .WRAP(1)) u_dut_wrap (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load),
    .load_sel(load_sel), .load_val(load_val), .lap(lap),
    .min_t(d_mt[0]), .min_o(d_mo[0]), .sec_t(d_st[0]), .sec_o(d_so[0]),
    .lap_min_t(d_lmt[0]), .lap_min_o(d_lmo[0]), .lap_sec_t(d_lst[0]), .lap_sec_o(d_lso[0]),
    .lap_vld(d_vld[0]), .expired(d_exp[0]), .wrapped(d_wrp[0])
  );

  timer_core #(.TICK_DIV(TD), .MAX_MIN(MM), .WRAP(0)) u_dut_sat (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load),
    .load_sel(load_sel), .load_val(load_val), .lap(lap),
    .min_t(d_mt[1]), .min_o(d_mo[1]), .sec_t(d_st[1]), .sec_o(d_so[1]),
    .lap_min_t(d_lmt[1]), .lap_min_o(d_lmo[1]), .lap_sec_t(d_lst[1]), .lap_sec_o(d_lso[1]),
    .lap_vld(d_vld[1]), .expired(d_exp[1]), .wrapped(d_wrp[1])
  );

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dut_time(input int w);
    return {d_mt[w], d_mo[w], d_st[w], d_so[w]};
  endfunction

  function automatic logic [15:0] dut_lap(input int w);
    return {d_lmt[w], d_lmo[w], d_lst[w], d_lso[w]};
  endfunction

  function automatic int load_apply(input int secs, input int sel, input int val);
    int m, s, mt, mo, st, so;
    m = secs / 60; s = secs % 60;
    mt = m / 10; mo = m % 10; st = s / 10; so = s % 10;
    case (sel)
      0:       so = (val > 9) ? 9 : val;
      1:       st = (val > 5) ? 5 : val;
      2:       mo = (val > 9) ? 9 : val;
      default: mt = val;
    endcase
    m = mt * 10 + mo;
    if (m > MM) m = MM;
    return m * 60 + st * 10 + so;
  endfunction

  // Advance one clock edge, update the model with the inputs seen at that edge,
  // then sample the DUT 1 time unit later.
  task automatic step();
    bit tk;
    @(posedge clk);
    if (rst) begin
      m_div = 0; m_vld = 0;
      for (int w = 0; w < 2; w++) begin
        m_secs[w] = 0; m_lap[w] = 0; m_wrp[w] = 0; m_exp[w] = 0;
      end
    end else begin
      tk = run && (m_div == TD - 1) && !load;
      if (load) m_div = 0;
      else if (run) m_div = (m_div == TD - 1) ? 0 : m_div + 1;
      for (int w = 0; w < 2; w++) begin
        m_wrp[w] = 0; m_exp[w] = 0;
        if (load) begin
          m_secs[w] = load_apply(m_secs[w], int'(load_sel), int'(load_val));
        end else if (tk) begin
          if (!dir) begin
            if (m_secs[w] == MAXS) begin
              if (w == 0) begin m_secs[w] = 0; m_wrp[w] = 1; end
            end else begin
              m_secs[w] = m_secs[w] + 1;
            end
          end else if (m_secs[w] != 0) begin
            m_secs[w] = m_secs[w] - 1;
            if (m_secs[w] == 0) m_exp[w] = 1;
          end
        end
        m_wrp_cnt[w] += int'(m_wrp[w]);
        m_exp_cnt[w] += int'(m_exp[w]);
      end
`ifdef TIMER_CORE_LAP_EN
      if (lap) begin
        m_lap[0] = m_secs[0]; m_lap[1] = m_secs[1]; m_vld = 1;
      end
`endif
    end
    #1;
    for (int w = 0; w < 2; w++) begin
      if (d_wrp[w]) d_wrp_cnt[w]++;
      if (d_exp[w]) d_exp_cnt[w]++;
    end
  endtask

  task automatic do_load(input int sel, input int val);
    load = 1'b1; load_sel = 2'(sel); load_val = 4'(val);
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    step(); step();
    rst = 1'b0; run = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (dut_time(w) !== 16'h0000) begin
        errors++; $display("FAIL reset_time[%0d]: got %h expected 0000", w, dut_time(w));
      end
      checks++;
      if (dut_lap(w) !== 16'h0000) begin
        errors++; $display("FAIL reset_lap[%0d]: got %h expected 0000", w, dut_lap(w));
      end
      checks++;
      if ({d_vld[w], d_exp[w], d_wrp[w]} !== 3'b000) begin
        errors++; $display("FAIL reset_flags[%0d]: got vld/exp/wrp=%b expected 000", w,
                           {d_vld[w], d_exp[w], d_wrp[w]});
      end
    end
    $display("test_reset done: time=%h", dut_time(0));
  endtask

  task automatic test_up_count();
    rst = 1'b1; step(); rst = 1'b0;
    run = 1'b1; dir = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (dut_time(0) !== to_bcd(m_secs[0])) begin
        errors++; $display("FAIL up_count cycle %0d: got %h expected %h", i, dut_time(0), to_bcd(m_secs[0]));
      end
    end
    checks++;
    if (dut_time(0) !== 16'h0010) begin
      errors++; $display("FAIL up_count_40clk: got %h expected 0010", dut_time(0));
    end
    $display("test_up_count done: time=%h", dut_time(0));
  endtask

  task automatic test_wrap();
    int c0, c1;
    run = 1'b0; dir = 1'b0;
    do_load(3, 5); do_load(2, 9); do_load(1, 5); do_load(0, 8);
    checks++;
    if (dut_time(0) !== 16'h5958 || dut_time(1) !== 16'h5958) begin
      errors++; $display("FAIL wrap_load: got %h/%h expected 5958", dut_time(0), dut_time(1));
    end
    run = 1'b1;
    repeat (TD) step();
    checks++;
    if (dut_time(0) !== 16'h5959 || dut_time(1) !== 16'h5959) begin
      errors++; $display("FAIL wrap_first_tick: got %h/%h expected 5959", dut_time(0), dut_time(1));
    end
    c0 = d_wrp_cnt[0]; c1 = d_wrp_cnt[1];
    repeat (TD) step();
    checks++;
    if (dut_time(0) !== 16'h0000 || d_wrp[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_to_zero: got %h wrapped=%b expected 0000 wrapped=1", dut_time(0), d_wrp[0]);
    end
    checks++;
    if (dut_time(1) !== 16'h5959) begin
      errors++; $display("FAIL sat_hold: got %h expected 5959", dut_time(1));
    end
    run = 1'b0;
    repeat (3) step();
    checks++;
    if (d_wrp_cnt[0] - c0 !== 1) begin
      errors++; $display("FAIL wrap_pulse_len: got %0d cycles expected 1", d_wrp_cnt[0] - c0);
    end
    checks++;
    if (d_wrp_cnt[1] - c1 !== 0) begin
      errors++; $display("FAIL sat_no_pulse: got %0d cycles expected 0", d_wrp_cnt[1] - c1);
    end
    $display("test_wrap done: wrap=%h sat=%h", dut_time(0), dut_time(1));
  endtask

  task automatic test_countdown();
    int e0;
    run = 1'b0; dir = 1'b1;
    do_load(3, 0); do_load(2, 1); do_load(1, 0); do_load(0, 0);
    run = 1'b1;
    repeat (TD) step();
    checks++;
    if (dut_time(0) !== 16'h0059 || dut_time(1) !== 16'h0059) begin
      errors++; $display("FAIL down_borrow: got %h/%h expected 0059", dut_time(0), dut_time(1));
    end
    run = 1'b0;
    do_load(3, 0); do_load(2, 0); do_load(1, 0); do_load(0, 1);
    e0 = d_exp_cnt[0];
    run = 1'b1;
    repeat (TD) step();
    checks++;
    if (dut_time(0) !== 16'h0000 || d_exp[0] !== 1'b1) begin
      errors++; $display("FAIL down_expire: got %h expired=%b expected 0000 expired=1", dut_time(0), d_exp[0]);
    end
    repeat (3 * TD) step();
    checks++;
    if (dut_time(0) !== 16'h0000 || d_exp_cnt[0] - e0 !== 1) begin
      errors++; $display("FAIL down_hold_zero: got %h pulses=%0d expected 0000 pulses=1", dut_time(0), d_exp_cnt[0] - e0);
    end
    $display("test_countdown done: time=%h", dut_time(0));
  endtask

  task automatic test_pause_load();
    logic [15:0] snap;
    run = 1'b1; dir = 1'b0;
    repeat ($urandom_range(5, 20)) step();
    snap = dut_time(0);
    run = 1'b0;
    repeat (20) step();
    checks++;
    if (dut_time(0) !== snap) begin
      errors++; $display("FAIL pause_frozen: got %h expected %h", dut_time(0), snap);
    end
    run = 1'b1;
    for (int i = 0; i < 2 * TD; i++) begin
      step();
      checks++;
      if (dut_time(0) !== to_bcd(m_secs[0])) begin
        errors++; $display("FAIL pause_resume cycle %0d: got %h expected %h", i, dut_time(0), to_bcd(m_secs[0]));
      end
    end
    do_load(1, 8);
    checks++;
    if (d_st[0] !== 4'd5) begin
      errors++; $display("FAIL load_clamp_sec_t: got %0d expected 5", d_st[0]);
    end
    for (int i = 0; i < TD && m_div != TD - 1; i++) step();
    do_load(0, 3);
    snap = dut_time(0);
    checks++;
    if (snap !== to_bcd(m_secs[0]) || d_so[0] !== 4'd3) begin
      errors++; $display("FAIL load_drops_tick: got %h expected %h", snap, to_bcd(m_secs[0]));
    end
    repeat (TD - 1) step();
    checks++;
    if (dut_time(0) !== snap) begin
      errors++; $display("FAIL load_clears_div: got %h expected %h", dut_time(0), snap);
    end
    step();
    checks++;
    if (dut_time(0) !== to_bcd(m_secs[0]) || d_so[0] !== 4'd4) begin
      errors++; $display("FAIL tick_after_load: got %h expected %h", dut_time(0), to_bcd(m_secs[0]));
    end
    $display("test_pause_load done: time=%h", dut_time(0));
  endtask

  task automatic test_lap();
    logic [15:0] exp_lap;
    logic        exp_vld;
    rst = 1'b1; step(); rst = 1'b0;
    run = 1'b1; dir = 1'b0;
    repeat (7 * TD) step();
    lap = 1'b1; step(); lap = 1'b0;
    repeat (2 * TD - 1) step();
`ifdef TIMER_CORE_LAP_EN
    exp_lap = 16'h0007; exp_vld = 1'b1;
`else
    exp_lap = 16'h0000; exp_vld = 1'b0;
`endif
    checks++;
    if (dut_time(0) !== 16'h0009) begin
      errors++; $display("FAIL lap_counting: got %h expected 0009", dut_time(0));
    end
    checks++;
    if (dut_lap(0) !== exp_lap || d_vld[0] !== exp_vld) begin
      errors++; $display("FAIL lap_capture: got %h vld=%b expected %h vld=%b", dut_lap(0), d_vld[0], exp_lap, exp_vld);
    end
    $display("test_lap done: lap=%h vld=%b", dut_lap(0), d_vld[0]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      run      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      load     = ($urandom_range(0, 5) == 0);
      load_sel = 2'($urandom_range(0, 3));
      load_val = 4'($urandom_range(0, 15));
      lap      = ($urandom_range(0, 9) == 0);
      step();
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (dut_time(w) !== to_bcd(m_secs[w]) || dut_lap(w) !== to_bcd(m_lap[w]) ||
            d_vld[w] !== 1'(m_vld) || d_exp[w] !== m_exp[w] || d_wrp[w] !== m_wrp[w]) begin
          errors++;
          $display("FAIL random[%0d] dut%0d: got t=%h l=%h v=%b e=%b w=%b expected t=%h l=%h v=%b e=%b w=%b",
                   i, w, dut_time(w), dut_lap(w), d_vld[w], d_exp[w], d_wrp[w],
                   to_bcd(m_secs[w]), to_bcd(m_lap[w]), 1'(m_vld), m_exp[w], m_wrp[w]);
        end
      end
    end
    rst = 1'b0; load = 1'b0; lap = 1'b0;
    $display("test_random done: wraps=%0d expiries=%0d", m_wrp_cnt[0], m_exp_cnt[0]);
  endtask

  task automatic test_reset_midcount();
    run = 1'b1; dir = 1'b0;
    repeat (9) step();
    for (int i = 0; i < TD && m_div != TD - 1; i++) step();
    rst = 1'b1; load = 1'b1; load_sel = 2'd0; load_val = 4'd7; lap = 1'b1;
    step();
    rst = 1'b0; load = 1'b0; lap = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (dut_time(w) !== 16'h0000 || dut_lap(w) !== 16'h0000 ||
          {d_vld[w], d_exp[w], d_wrp[w]} !== 3'b000) begin
        errors++; $display("FAIL reset_midcount[%0d]: got t=%h l=%h flags=%b expected all 0", w,
                           dut_time(w), dut_lap(w), {d_vld[w], d_exp[w], d_wrp[w]});
      end
    end
    repeat (TD) step();
    checks++;
    if (dut_time(0) !== 16'h0001) begin
      errors++; $display("FAIL reset_clears_div: got %h expected 0001", dut_time(0));
    end
    $display("test_reset_midcount done: time=%h", dut_time(0));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dir = 1'b0; load = 1'b0; lap = 1'b0;
    load_sel = 2'd0; load_val = 4'd0;
    m_div = 0; m_vld = 0;
    for (int w = 0; w < 2; w++) begin
      m_secs[w] = 0; m_lap[w] = 0; m_wrp[w] = 0; m_exp[w] = 0;
      m_wrp_cnt[w] = 0; m_exp_cnt[w] = 0; d_wrp_cnt[w] = 0; d_exp_cnt[w] = 0;
    end
    test_reset();
    test_up_count();
    test_wrap();
    test_countdown();
    test_pause_load();
    test_lap();
    test_random();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
